// File: rtl/rom_access_arbiter.sv
// ---------------------------------------------------------------------------
// rom_access_arbiter
//
// Shares one combinational program ROM (16-bit word, 8-bit address) between
// the instruction-fetch (IF) and data-load (DL) requesters. A winning address
// is registered onto ROM_ADDR and held for WAIT_CYCLES cycles. The ROM word is
// then captured and returned to the granted requester with a one-cycle
// RVALID pulse.
//
// Handshake: a requester raises REQ with a stable ADDR. It keeps both until it
// sees its one-cycle GNT pulse. REQ must then be dropped, or moved to a new
// address, by the following edge. Read data comes back later as a one-cycle
// RVALID pulse, and RDATA holds its value until the next capture for that
// requester. There is no back-pressure on the return path.
//
// Ports:
//   CLK        in   1   system clock, rising edge
//   RST_N      in   1   synchronous active-low reset
//   IF_REQ     in   1   fetch request
//   IF_ADDR    in   8   fetch address
//   IF_GNT     out  1   pulse: fetch request accepted
//   IF_RDATA   out  16  fetched word (valid with IF_RVALID, then held)
//   IF_RVALID  out  1   pulse: IF_RDATA updated
//   DL_*              same as IF_* for the data-load requester
//   ERR        out  1   pulse with RVALID when the served address >= ROM_DEPTH
//   BUSY       out  1   high while an access is in flight (exposes FSM state)
//   ROM_ADDR   out  8   registered ROM address
//   ROM_VALUE  in   16  ROM data, combinational from ROM_ADDR
//
// Parameters:
//   WAIT_CYCLES  ROM access cycles, from the grant edge to the capture edge
//                (legal range 1..15)
//   ROM_DEPTH    number of implemented ROM words
// ---------------------------------------------------------------------------
module rom_access_arbiter #(
   parameter int WAIT_CYCLES = 1,
   parameter int ROM_DEPTH   = 8
) (
   input  logic        CLK,
   input  logic        RST_N,
   input  logic        IF_REQ,
   input  logic [7:0]  IF_ADDR,
   output logic        IF_GNT,
   output logic [15:0] IF_RDATA,
   output logic        IF_RVALID,
   input  logic        DL_REQ,
   input  logic [7:0]  DL_ADDR,
   output logic        DL_GNT,
   output logic [15:0] DL_RDATA,
   output logic        DL_RVALID,
   output logic        ERR,
   output logic        BUSY,
   output logic [7:0]  ROM_ADDR,
   input  logic [15:0] ROM_VALUE
);

   typedef enum logic {IDLE = 1'b0, ACCESS = 1'b1} state_t;

   localparam logic [3:0] cnt_load  = 4'(WAIT_CYCLES - 1);
   // One bit wider than the address, so a depth of 256 is still representable.
   localparam logic [8:0] depth_lim = 9'(ROM_DEPTH);
   localparam logic       own_if    = 1'b0;
   localparam logic       own_dl    = 1'b1;

   state_t      state_q, state_d;
   logic [7:0]  addr_q, addr_d;
   logic        owner_q, owner_d;
   logic        last_q, last_d;
   logic [3:0]  cnt_q, cnt_d;
   logic        if_gnt_q, if_gnt_d, dl_gnt_q, dl_gnt_d;
   logic        if_rvalid_q, if_rvalid_d, dl_rvalid_q, dl_rvalid_d;
   logic        err_q, err_d;
   logic [15:0] if_rdata_q, if_rdata_d, dl_rdata_q, dl_rdata_d;
   logic        pick_dl;
   logic        out_of_range;
   logic [15:0] word;

   always_comb begin
      state_d      = state_q;
      addr_d       = addr_q;
      owner_d      = owner_q;
      last_d       = last_q;
      cnt_d        = cnt_q;
      if_gnt_d     = 1'b0;
      dl_gnt_d     = 1'b0;
      if_rvalid_d  = 1'b0;
      dl_rvalid_d  = 1'b0;
      err_d        = 1'b0;
      if_rdata_d   = if_rdata_q;
      dl_rdata_d   = dl_rdata_q;
      // DL wins when it is alone, or on a tie when IF was served last.
      pick_dl      = DL_REQ && (!IF_REQ || (last_q == own_if));
      out_of_range = ({1'b0, addr_q} >= depth_lim);
      word         = out_of_range ? 16'h0000 : ROM_VALUE;

      case (state_q)
         IDLE: begin
            if (IF_REQ || DL_REQ) begin
               addr_d   = pick_dl ? DL_ADDR : IF_ADDR;
               owner_d  = pick_dl;
               last_d   = pick_dl;
               if_gnt_d = !pick_dl;
               dl_gnt_d = pick_dl;
               cnt_d    = cnt_load;
               state_d  = ACCESS;
            end
         end
         ACCESS: begin
            if (cnt_q != 4'd0) begin
               cnt_d = cnt_q - 4'd1;
            end else begin
               if (owner_q == own_dl) begin
                  dl_rdata_d  = word;
                  dl_rvalid_d = 1'b1;
               end else begin
                  if_rdata_d  = word;
                  if_rvalid_d = 1'b1;
               end
               err_d   = out_of_range;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         state_q     <= IDLE;
         addr_q      <= 8'h00;
         owner_q     <= own_if;
         last_q      <= own_dl;
         cnt_q       <= 4'd0;
         if_gnt_q    <= 1'b0;
         dl_gnt_q    <= 1'b0;
         if_rvalid_q <= 1'b0;
         dl_rvalid_q <= 1'b0;
         err_q       <= 1'b0;
         if_rdata_q  <= 16'h0000;
         dl_rdata_q  <= 16'h0000;
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         owner_q     <= owner_d;
         last_q      <= last_d;
         cnt_q       <= cnt_d;
         if_gnt_q    <= if_gnt_d;
         dl_gnt_q    <= dl_gnt_d;
         if_rvalid_q <= if_rvalid_d;
         dl_rvalid_q <= dl_rvalid_d;
         err_q       <= err_d;
         if_rdata_q  <= if_rdata_d;
         dl_rdata_q  <= dl_rdata_d;
      end
   end

   assign IF_GNT    = if_gnt_q;
   assign DL_GNT    = dl_gnt_q;
   assign IF_RVALID = if_rvalid_q;
   assign DL_RVALID = dl_rvalid_q;
   assign IF_RDATA  = if_rdata_q;
   assign DL_RDATA  = dl_rdata_q;
   assign ERR       = err_q;
   assign BUSY      = (state_q == ACCESS);
   assign ROM_ADDR  = addr_q;

endmodule

// File: tb/tb_rom_access_arbiter.sv
// ---------------------------------------------------------------------------
// tb_rom_access_arbiter
//
// Directed bench for rom_access_arbiter. Two instances share the clock and
// the reset: inst a uses WAIT_CYCLES=1 and inst b uses WAIT_CYCLES=3. Each has
// its own behavioural ROM. Inputs are driven 1 ns after a rising edge, and
// outputs are sampled at that same point.
// ---------------------------------------------------------------------------
module tb_rom_access_arbiter;

   logic clk;
   logic rst_n;

   logic        a_if_req, a_dl_req, a_if_gnt, a_dl_gnt, a_if_rvalid, a_dl_rvalid;
   logic        a_err, a_busy;
   logic [7:0]  a_if_addr, a_dl_addr, a_rom_addr;
   logic [15:0] a_if_rdata, a_dl_rdata, a_rom_value;

   logic        b_if_req, b_dl_req, b_if_gnt, b_dl_gnt, b_if_rvalid, b_dl_rvalid;
   logic        b_err, b_busy;
   logic [7:0]  b_if_addr, b_dl_addr, b_rom_addr;
   logic [15:0] b_if_rdata, b_dl_rdata, b_rom_value;

   int errors = 0;
   int checks = 0;

   // Contents of the ROM the test plan uses. Every other word is C0xx, so an
   // out-of-range read that is not masked shows up as a nonzero value.
   function automatic logic [15:0] rom_word(input logic [7:0] a);
      case (a)
         8'd0:    rom_word = 16'h1003;
         8'd1:    rom_word = 16'hFFFF;
         8'd3:    rom_word = 16'h4001;
         8'd4:    rom_word = 16'h5200;
         default: rom_word = {8'hC0, a};
      endcase
   endfunction

   assign a_rom_value = rom_word(a_rom_addr);
   assign b_rom_value = rom_word(b_rom_addr);

   rom_access_arbiter #(.WAIT_CYCLES(1), .ROM_DEPTH(8)) u_a (
      .CLK(clk), .RST_N(rst_n),
      .IF_REQ(a_if_req), .IF_ADDR(a_if_addr), .IF_GNT(a_if_gnt),
      .IF_RDATA(a_if_rdata), .IF_RVALID(a_if_rvalid),
      .DL_REQ(a_dl_req), .DL_ADDR(a_dl_addr), .DL_GNT(a_dl_gnt),
      .DL_RDATA(a_dl_rdata), .DL_RVALID(a_dl_rvalid),
      .ERR(a_err), .BUSY(a_busy), .ROM_ADDR(a_rom_addr), .ROM_VALUE(a_rom_value)
   );

   rom_access_arbiter #(.WAIT_CYCLES(3), .ROM_DEPTH(8)) u_b (
      .CLK(clk), .RST_N(rst_n),
      .IF_REQ(b_if_req), .IF_ADDR(b_if_addr), .IF_GNT(b_if_gnt),
      .IF_RDATA(b_if_rdata), .IF_RVALID(b_if_rvalid),
      .DL_REQ(b_dl_req), .DL_ADDR(b_dl_addr), .DL_GNT(b_dl_gnt),
      .DL_RDATA(b_dl_rdata), .DL_RVALID(b_dl_rvalid),
      .ERR(b_err), .BUSY(b_busy), .ROM_ADDR(b_rom_addr), .ROM_VALUE(b_rom_value)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic apply_reset();
      rst_n = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      a_if_req = 0; a_dl_req = 0; a_if_addr = 0; a_dl_addr = 0;
      b_if_req = 0; b_dl_req = 0; b_if_addr = 0; b_dl_addr = 0;
      apply_reset();
      checks++;
      if ({a_if_gnt, a_dl_gnt, a_if_rvalid, a_dl_rvalid, a_err, a_busy} !== 6'b0) begin
         errors++; $display("FAIL reset_a_pulses: got %b expected 000000",
            {a_if_gnt, a_dl_gnt, a_if_rvalid, a_dl_rvalid, a_err, a_busy});
      end
      checks++;
      if ({a_rom_addr, a_if_rdata, a_dl_rdata} !== 40'h0) begin
         errors++; $display("FAIL reset_a_regs: got %h expected 0",
            {a_rom_addr, a_if_rdata, a_dl_rdata});
      end
      checks++;
      if ({b_if_gnt, b_dl_gnt, b_if_rvalid, b_dl_rvalid, b_err, b_busy} !== 6'b0) begin
         errors++; $display("FAIL reset_b_pulses: got %b expected 000000",
            {b_if_gnt, b_dl_gnt, b_if_rvalid, b_dl_rvalid, b_err, b_busy});
      end
      checks++;
      if ({b_rom_addr, b_if_rdata, b_dl_rdata} !== 40'h0) begin
         errors++; $display("FAIL reset_b_regs: got %h expected 0",
            {b_rom_addr, b_if_rdata, b_dl_rdata});
      end
   endtask

   task automatic test_single_fetch();
      a_if_req = 1; a_if_addr = 8'd3;
      tick();  // E0: grant
      a_if_req = 0;
      checks++;
      if ({a_if_gnt, a_dl_gnt, a_busy, a_if_rvalid, a_rom_addr} !== {4'b1010, 8'd3}) begin
         errors++; $display("FAIL fetch_grant: got gnt=%b%b busy=%b rv=%b addr=%h expected 1 0 1 0 03",
            a_if_gnt, a_dl_gnt, a_busy, a_if_rvalid, a_rom_addr);
      end
      tick();  // E1: capture
      checks++;
      if ({a_if_rvalid, a_err, a_if_gnt, a_if_rdata} !== {3'b100, 16'h4001}) begin
         errors++; $display("FAIL fetch_data: got rv=%b err=%b gnt=%b data=%h expected 1 0 0 4001",
            a_if_rvalid, a_err, a_if_gnt, a_if_rdata);
      end
      checks++;
      if ({a_dl_gnt, a_dl_rvalid, a_dl_rdata} !== 18'h0) begin
         errors++; $display("FAIL fetch_dl_quiet: got %h expected 0",
            {a_dl_gnt, a_dl_rvalid, a_dl_rdata});
      end
      tick();  // E2: pulse gone, data held
      checks++;
      if ({a_if_rvalid, a_busy, a_if_rdata} !== {2'b00, 16'h4001}) begin
         errors++; $display("FAIL fetch_after: got rv=%b busy=%b data=%h expected 0 0 4001",
            a_if_rvalid, a_busy, a_if_rdata);
      end
   endtask

   task automatic test_round_robin();
      logic exp_dl;
      apply_reset();
      a_if_req = 1; a_if_addr = 8'd0;
      a_dl_req = 1; a_dl_addr = 8'd4;
      for (int k = 0; k < 6; k++) begin
         exp_dl = (k % 2 == 1);
         tick();  // grant edge
         checks++;
         if ({a_if_gnt, a_dl_gnt, a_rom_addr} !== {!exp_dl, exp_dl, (exp_dl ? 8'd4 : 8'd0)}) begin
            errors++; $display("FAIL rr_grant_%0d: got gnt=%b%b addr=%h expected dl=%b",
               k, a_if_gnt, a_dl_gnt, a_rom_addr, exp_dl);
         end
         tick();  // capture edge
         checks++;
         if ({a_if_gnt, a_dl_gnt, a_if_rvalid, a_dl_rvalid} !== {2'b00, !exp_dl, exp_dl}) begin
            errors++; $display("FAIL rr_valid_%0d: got gnt=%b%b rv=%b%b expected dl=%b",
               k, a_if_gnt, a_dl_gnt, a_if_rvalid, a_dl_rvalid, exp_dl);
         end
         checks++;
         if ((exp_dl ? a_dl_rdata : a_if_rdata) !== (exp_dl ? 16'h5200 : 16'h1003)) begin
            errors++; $display("FAIL rr_data_%0d: got if=%h dl=%h", k, a_if_rdata, a_dl_rdata);
         end
      end
      a_if_req = 0; a_dl_req = 0;
      tick();
   endtask

   task automatic test_wait3();
      b_dl_req = 1; b_dl_addr = 8'd1;
      tick();  // E0
      b_dl_req = 0;
      checks++;
      if ({b_dl_gnt, b_if_gnt, b_busy, b_rom_addr} !== {3'b101, 8'd1}) begin
         errors++; $display("FAIL w3_grant: got gnt=%b%b busy=%b addr=%h expected 1 0 1 01",
            b_dl_gnt, b_if_gnt, b_busy, b_rom_addr);
      end
      b_if_req = 1; b_if_addr = 8'd3;  // raised mid-access
      for (int k = 1; k < 3; k++) begin
         tick();
         checks++;
         if ({b_busy, b_if_gnt, b_dl_rvalid, b_dl_gnt} !== 4'b1000) begin
            errors++; $display("FAIL w3_wait_E%0d: got busy=%b ifgnt=%b rv=%b dlgnt=%b expected 1 0 0 0",
               k, b_busy, b_if_gnt, b_dl_rvalid, b_dl_gnt);
         end
      end
      tick();  // E3: capture
      checks++;
      if ({b_dl_rvalid, b_busy, b_if_gnt, b_err, b_if_rvalid, b_dl_rdata} !== {5'b10000, 16'hFFFF}) begin
         errors++; $display("FAIL w3_capture: got rv=%b busy=%b ifgnt=%b err=%b ifrv=%b data=%h expected 1 0 0 0 0 ffff",
            b_dl_rvalid, b_busy, b_if_gnt, b_err, b_if_rvalid, b_dl_rdata);
      end
      tick();  // E4: pending IF now granted
      b_if_req = 0;
      checks++;
      if ({b_if_gnt, b_dl_rvalid, b_rom_addr, b_dl_rdata} !== {2'b10, 8'd3, 16'hFFFF}) begin
         errors++; $display("FAIL w3_if_grant: got gnt=%b rv=%b addr=%h dldata=%h expected 1 0 03 ffff",
            b_if_gnt, b_dl_rvalid, b_rom_addr, b_dl_rdata);
      end
      tick(); tick(); tick();  // E7: IF capture
      checks++;
      if ({b_if_rvalid, b_dl_rvalid, b_if_rdata, b_dl_rdata} !== {2'b10, 16'h4001, 16'hFFFF}) begin
         errors++; $display("FAIL w3_if_data: got rv=%b%b if=%h dl=%h expected 1 0 4001 ffff",
            b_if_rvalid, b_dl_rvalid, b_if_rdata, b_dl_rdata);
      end
      tick();
   endtask

   task automatic test_out_of_range();
      // Address 7 is the last valid word, and 8 is the first invalid one.
      a_if_req = 1; a_if_addr = 8'd7;
      tick();
      a_if_req = 0;
      tick();
      checks++;
      if ({a_if_rvalid, a_err, a_if_rdata} !== {2'b10, 16'hC007}) begin
         errors++; $display("FAIL oor_last_valid: got rv=%b err=%b data=%h expected 1 0 c007",
            a_if_rvalid, a_err, a_if_rdata);
      end
      a_if_req = 1; a_if_addr = 8'h08;
      tick();
      a_if_req = 0;
      checks++;
      if ({a_if_gnt, a_rom_addr, a_err} !== {1'b1, 8'h08, 1'b0}) begin
         errors++; $display("FAIL oor_grant: got gnt=%b addr=%h err=%b expected 1 08 0",
            a_if_gnt, a_rom_addr, a_err);
      end
      tick();
      checks++;
      if ({a_if_rvalid, a_err, a_if_rdata} !== {2'b11, 16'h0000}) begin
         errors++; $display("FAIL oor_capture: got rv=%b err=%b data=%h expected 1 1 0000",
            a_if_rvalid, a_err, a_if_rdata);
      end
      tick();
      checks++;
      if ({a_if_rvalid, a_err, a_dl_rdata} !== {2'b00, 16'h5200}) begin
         errors++; $display("FAIL oor_after: got rv=%b err=%b dldata=%h expected 0 0 5200",
            a_if_rvalid, a_err, a_dl_rdata);
      end
   endtask

   task automatic test_reset_mid_access();
      b_dl_req = 1; b_dl_addr = 8'd4;
      tick();  // grant
      b_dl_req = 0;
      checks++;
      if (b_dl_gnt !== 1'b1) begin
         errors++; $display("FAIL rma_grant: got %b expected 1", b_dl_gnt);
      end
      rst_n = 0;
      tick();  // reset edge right after the grant
      rst_n = 1;
      checks++;
      if ({b_busy, b_rom_addr, b_dl_gnt, b_dl_rvalid, b_err} !== 12'h0) begin
         errors++; $display("FAIL rma_after_reset: got busy=%b addr=%h gnt=%b rv=%b err=%b expected all 0",
            b_busy, b_rom_addr, b_dl_gnt, b_dl_rvalid, b_err);
      end
      for (int k = 0; k < 4; k++) begin
         tick();
         checks++;
         if ({b_dl_rvalid, b_if_rvalid, b_err, b_busy} !== 4'b0) begin
            errors++; $display("FAIL rma_no_valid_%0d: got rv=%b%b err=%b busy=%b expected 0",
               k, b_if_rvalid, b_dl_rvalid, b_err, b_busy);
         end
      end
      b_if_req = 1; b_if_addr = 8'd3;
      b_dl_req = 1; b_dl_addr = 8'd4;
      tick();
      b_if_req = 0; b_dl_req = 0;
      checks++;
      if ({b_if_gnt, b_dl_gnt, b_rom_addr} !== {2'b10, 8'd3}) begin
         errors++; $display("FAIL rma_tie: got gnt=%b%b addr=%h expected 1 0 03",
            b_if_gnt, b_dl_gnt, b_rom_addr);
      end
      tick(); tick(); tick();
      checks++;
      if ({b_if_rvalid, b_if_rdata} !== {1'b1, 16'h4001}) begin
         errors++; $display("FAIL rma_tie_data: got rv=%b data=%h expected 1 4001",
            b_if_rvalid, b_if_rdata);
      end
      tick();
   endtask

   task automatic test_idle_stability();
      a_dl_req = 1; a_dl_addr = 8'd4;
      tick();
      a_dl_req = 0;
      tick();
      checks++;
      if ({a_dl_rvalid, a_dl_rdata} !== {1'b1, 16'h5200}) begin
         errors++; $display("FAIL idle_read: got rv=%b data=%h expected 1 5200",
            a_dl_rvalid, a_dl_rdata);
      end
      for (int k = 0; k < 20; k++) begin
         tick();
         checks++;
         if ({a_if_gnt, a_dl_gnt, a_if_rvalid, a_dl_rvalid, a_err, a_busy, a_rom_addr, a_dl_rdata}
             !== {6'b0, 8'd4, 16'h5200}) begin
            errors++; $display("FAIL idle_hold_%0d: got pulses=%b addr=%h data=%h expected 0 04 5200",
               k, {a_if_gnt, a_dl_gnt, a_if_rvalid, a_dl_rvalid, a_err, a_busy},
               a_rom_addr, a_dl_rdata);
         end
      end
   endtask

   // ---------------- sequence and report ----------------
   initial begin
      rst_n = 1'b0;
      test_reset();
      test_single_fetch();
      test_round_robin();
      test_wait3();
      test_out_of_range();
      test_reset_mid_access();
      test_idle_stability();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
